lc3_mem_arbiter: RTL and testbench
==================================

# lc3_mem_arbiter

Shares the single LC-3 memory port between the CPU core's MAR/MDR memory cycles and a debug/loader port. Each requester uses a req/ack handshake; the arbiter serializes transactions, applies round-robin priority on contention, and lets the debug side halt CPU memory traffic. It sits between `lc3_if` memory signals and the synchronous memory model, so the controller's fetch, load and store states can stall on `cpu_ack`.

## Interface
- `AW`, 16: address width.
- `DW`, 16: data width.
- `MEM_LAT`, 1: memory read latency in cycles (legal 1..4); `mem_rdata` is valid `MEM_LAT` cycles after the `mem_en` cycle.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-low reset.
- `cpu_req`, `cpu_we` in 1 each: CPU request and write qualifier; held until ack.
- `cpu_addr` in AW, `cpu_wdata` in DW: CPU address and write data.
- `cpu_ack` out 1: one-cycle completion pulse to the CPU.
- `cpu_rdata` out DW: CPU read data, valid while `cpu_ack` is high.
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`, `dbg_ack`, `dbg_rdata`: same meanings for the debug port.
- `dbg_halt` in 1: while high, CPU requests are never granted.
- `cpu_halted` out 1: `dbg_halt` is high and no CPU transaction is in flight.
- `mem_en`, `mem_we` out 1 each: memory strobe and write enable.
- `mem_addr` out AW, `mem_wdata` out DW: memory address and write data.
- `mem_rdata` in DW: memory read data.
- `busy` out 1: state is not IDLE.

## Operation
- FSM states: IDLE, ACCESS, WAIT, DONE.
- **IDLE:**
  - Sample requests. An eligible request is `dbg_req`, or `cpu_req && !dbg_halt`.
  - With one eligible request, grant it.
  - With two, grant the owner opposite `last_gnt`.
  - On grant: latch owner, we, addr and wdata; update `last_gnt`; go to ACCESS.
- **ACCESS:**
  - `mem_en` is high. `mem_we` equals the latched we. `mem_addr`/`mem_wdata` come from the latches.
  - Writes go to DONE. Reads go to WAIT with `lat_cnt = MEM_LAT-1`.
- **WAIT:**
  - Decrement `lat_cnt` each cycle.
  - When `lat_cnt == 0`, capture `mem_rdata` into `rdata_q` and go to DONE.
- **DONE:**
  - Pulse the owner's ack for one cycle. Both `*_rdata` ports are driven from `rdata_q`.
  - Return to IDLE. Requests are ignored in DONE.
- Requester rule: drop or change `req` on the edge where ack is sampled high. A request held past that edge is a new transaction.
- Latched fields are frozen from grant to DONE. Changes on the request inputs mid-transaction have no effect.
- `dbg_halt` rising mid-CPU-transaction does not abort it. `cpu_halted` rises in the cycle after that transaction's DONE.
- Outside ACCESS, `mem_addr`/`mem_wdata` hold their last values and `mem_en`/`mem_we` are 0.
- Reset values:
  - state IDLE; `mem_en`, `mem_we`, both acks, `busy`, `cpu_halted` all 0.
  - `mem_addr`, `mem_wdata`, `rdata_q` all 0; `lat_cnt` 0.
  - `last_gnt` = CPU, so debug wins the first tie.
- Reset asserted mid-transaction: abort immediately, no ack issued, memory strobes drop asynchronously.

## Timing
- Request seen in IDLE at cycle t:
  - ACCESS at t+1.
  - Write ack at t+2.
  - Read ack at t+2+MEM_LAT.
- Minimum spacing between grants is one IDLE cycle after DONE.
- Throughput per transaction: 3 cycles for a write, 3+MEM_LAT cycles for a read.
- All outputs are registered or decoded from state only. There is no combinational path from `*_req` to `*_ack`.
- `lat_cnt` is 2 bits wide and never wraps: WAIT exits at 0.

## Structure
- Package `lc3_arb_pkg` contains:
  - `arb_state_t` enum (IDLE, ACCESS, WAIT, DONE).
  - `owner_t` enum (OWN_CPU, OWN_DBG).
  - Default constants for AW, DW and MEM_LAT.
- Sub-module `lc3_rr_pick2`: combinational 2-way round-robin picker. Inputs: two eligible bits and `last_gnt`. Outputs: `grant_valid` and `owner`.
- All other logic stays in `lc3_mem_arbiter`.

## Test plan
- CPU read, MEM_LAT=1, addr 0x3000, memory holds 0x1234 → `mem_en` at t+1, `cpu_ack` at t+3, `cpu_rdata` = 0x1234, `dbg_ack` stays 0.
- Debug write 0xBEEF to 0x4000 → `mem_en`=`mem_we`=1 for exactly one cycle with that addr/data, `dbg_ack` at t+2; a follow-up CPU read of 0x4000 returns 0xBEEF.
- Both requesting continuously from reset → grants go DBG, CPU, DBG, CPU; each ack is a single-cycle pulse.
- `dbg_halt`=1 with `cpu_req` held → no `cpu_ack` for 20 cycles and `cpu_halted`=1; release halt → CPU granted the next IDLE cycle.
- MEM_LAT=4 read from 0x0005 → `cpu_ack` at t+6, `busy` high from t+1 through t+6.
- `rst` low during WAIT → `busy`, `mem_en` and both acks go to 0 at once; no ack after release; a new request completes normally.

Source files
------------

// File: rtl/lc3_arb_pkg.sv
// Shared types and default sizing for the LC-3 memory-port arbiter.
package lc3_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    DONE
  } arb_state_t;

  typedef enum logic {
    OWN_CPU,
    OWN_DBG
  } owner_t;

  localparam int ARB_AW      = 16;
  localparam int ARB_DW      = 16;
  localparam int ARB_MEM_LAT = 1;

endpackage

// File: rtl/lc3_rr_pick2.sv
// Two-way round-robin picker: on a tie the requester that did not win last time is chosen.
module lc3_rr_pick2
  import lc3_arb_pkg::*;
(
  input  logic   cpu_elig,
  input  logic   dbg_elig,
  input  owner_t last_gnt,
  output logic   grant_valid,
  output owner_t owner
);

  always_comb begin
    grant_valid = cpu_elig || dbg_elig;
    owner       = OWN_CPU;
    if (cpu_elig && dbg_elig) begin
      owner = (last_gnt == OWN_CPU) ? OWN_DBG : OWN_CPU;
    end else if (dbg_elig) begin
      owner = OWN_DBG;
    end
  end

endmodule

// File: rtl/lc3_mem_arbiter.sv
// Serializes CPU and debug req/ack transactions onto the single LC-3 memory port,
// with round-robin on contention and a debug-controlled halt of CPU traffic.
module lc3_mem_arbiter
  import lc3_arb_pkg::*;
#(
  parameter int AW      = ARB_AW,
  parameter int DW      = ARB_DW,
  parameter int MEM_LAT = ARB_MEM_LAT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_ack,
  output logic [DW-1:0] dbg_rdata,
  input  logic          dbg_halt,
  output logic          cpu_halted,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam logic [1:0] LAT_INIT = 2'(MEM_LAT - 1);

  arb_state_t    state;
  owner_t        owner_q;
  owner_t        last_gnt;
  owner_t        pick_owner;
  logic          we_q;
  logic [1:0]    lat_cnt;
  logic [DW-1:0] rdata_q;
  logic          cpu_elig;
  logic          grant_valid;
  logic          cpu_flight_nxt;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  assign cpu_elig  = cpu_req && !dbg_halt;
  assign cpu_rdata = rdata_q;
  assign dbg_rdata = rdata_q;

  lc3_rr_pick2 u_pick (
    .cpu_elig    (cpu_elig),
    .dbg_elig    (dbg_req),
    .last_gnt    (last_gnt),
    .grant_valid (grant_valid),
    .owner       (pick_owner)
  );

  always_comb begin
    sel_we    = cpu_we;
    sel_addr  = cpu_addr;
    sel_wdata = cpu_wdata;
    if (pick_owner == OWN_DBG) begin
      sel_we    = dbg_we;
      sel_addr  = dbg_addr;
      sel_wdata = dbg_wdata;
    end
  end

  // A CPU transaction counts as in flight from grant until its DONE cycle ends.
  always_comb begin
    cpu_flight_nxt = 1'b0;
    case (state)
      IDLE:         cpu_flight_nxt = grant_valid && (pick_owner == OWN_CPU);
      ACCESS, WAIT: cpu_flight_nxt = (owner_q == OWN_CPU);
      default:      cpu_flight_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      owner_q    <= OWN_CPU;
      last_gnt   <= OWN_CPU;
      we_q       <= 1'b0;
      lat_cnt    <= 2'd0;
      rdata_q    <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_ack    <= 1'b0;
      dbg_ack    <= 1'b0;
      busy       <= 1'b0;
      cpu_halted <= 1'b0;
    end else begin
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      cpu_ack    <= 1'b0;
      dbg_ack    <= 1'b0;
      cpu_halted <= dbg_halt && !cpu_flight_nxt;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner_q   <= pick_owner;
            last_gnt  <= pick_owner;
            we_q      <= sel_we;
            mem_en    <= 1'b1;
            mem_we    <= sel_we;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            busy      <= 1'b1;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (we_q) begin
            cpu_ack <= (owner_q == OWN_CPU);
            dbg_ack <= (owner_q == OWN_DBG);
            state   <= DONE;
          end else begin
            lat_cnt <= LAT_INIT;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt == 2'd0) begin
            rdata_q <= mem_rdata;
            cpu_ack <= (owner_q == OWN_CPU);
            dbg_ack <= (owner_q == OWN_DBG);
            state   <= DONE;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Directed bench for lc3_mem_arbiter: one instance at MEM_LAT=1, one at MEM_LAT=4.
module tb_lc3_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, cpu_ack;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        dbg_req, dbg_we, dbg_ack;
  logic [15:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic        dbg_halt, cpu_halted;
  logic        mem_en, mem_we, busy;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  logic        c4_req, c4_ack, d4_ack, halted4, m4_en, m4_we, busy4;
  logic [15:0] c4_addr, c4_rdata, d4_rdata, m4_addr, m4_wdata, m4_rdata;

  logic        pl_en;
  logic [15:0] pl_addr, pl_data;
  logic [15:0] mem1 [0:65535];
  logic [15:0] mem4 [0:65535];
  logic [15:0] pipe4 [0:3];

  int total = 0;
  int passed = 0;
  int failed = 0;

  always #5 clk = ~clk;

  lc3_mem_arbiter #(.AW(16), .DW(16), .MEM_LAT(1)) u_dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .dbg_halt(dbg_halt), .cpu_halted(cpu_halted),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  lc3_mem_arbiter #(.AW(16), .DW(16), .MEM_LAT(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .cpu_req(c4_req), .cpu_we(1'b0), .cpu_addr(c4_addr), .cpu_wdata(16'h0000),
    .cpu_ack(c4_ack), .cpu_rdata(c4_rdata),
    .dbg_req(1'b0), .dbg_we(1'b0), .dbg_addr(16'h0000), .dbg_wdata(16'h0000),
    .dbg_ack(d4_ack), .dbg_rdata(d4_rdata),
    .dbg_halt(1'b0), .cpu_halted(halted4),
    .mem_en(m4_en), .mem_we(m4_we), .mem_addr(m4_addr), .mem_wdata(m4_wdata),
    .mem_rdata(m4_rdata), .busy(busy4)
  );

  // Memory models: read data appears exactly MEM_LAT cycles after the strobe, junk otherwise.
  always @(posedge clk) begin
    if (pl_en) mem1[pl_addr] <= pl_data;
    else if (mem_en && mem_we) mem1[mem_addr] <= mem_wdata;
    mem_rdata <= (mem_en && !mem_we) ? mem1[mem_addr] : 16'hDEAD;
  end

  always @(posedge clk) begin
    if (pl_en) mem4[pl_addr] <= pl_data;
    pipe4[0] <= (m4_en && !m4_we) ? mem4[m4_addr] : 16'hDEAD;
    for (int i = 1; i < 4; i++) pipe4[i] <= pipe4[i-1];
  end
  assign m4_rdata = pipe4[3];

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] seq [0:3];
    int         n;
    logic       prev_c, prev_d, seen;

    rst = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0; dbg_halt = 0;
    c4_req = 0; c4_addr = 0;
    pl_en = 0; pl_addr = 0; pl_data = 0;
    tick();
    pl_en = 1; pl_addr = 16'h3000; pl_data = 16'h1234;
    tick();
    pl_addr = 16'h0005; pl_data = 16'hA5C3;
    tick();
    pl_en = 0;

    check("rst_busy", busy, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_acks", {cpu_ack, dbg_ack}, 0);
    check("rst_halted", cpu_halted, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_rdata", cpu_rdata, 0);
    rst = 1'b1;
    tick();

    // CPU read 0x3000, MEM_LAT=1
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h3000;
    tick();
    check("rd_mem_en", mem_en, 1);
    check("rd_mem_we", mem_we, 0);
    check("rd_mem_addr", mem_addr, 16'h3000);
    check("rd_busy", busy, 1);
    tick();
    check("rd_wait_en", mem_en, 0);
    check("rd_early_ack", cpu_ack, 0);
    tick();
    check("rd_ack", cpu_ack, 1);
    check("rd_data", cpu_rdata, 16'h1234);
    check("rd_dbg_ack", dbg_ack, 0);
    cpu_req = 0;
    tick();
    check("rd_ack_pulse", cpu_ack, 0);
    check("rd_idle", busy, 0);

    // debug write 0xBEEF to 0x4000, then CPU reads it back
    dbg_req = 1; dbg_we = 1; dbg_addr = 16'h4000; dbg_wdata = 16'hBEEF;
    tick();
    check("wr_mem_en", mem_en, 1);
    check("wr_mem_we", mem_we, 1);
    check("wr_mem_addr", mem_addr, 16'h4000);
    check("wr_mem_wdata", mem_wdata, 16'hBEEF);
    tick();
    check("wr_en_one_cycle", {mem_en, mem_we}, 0);
    check("wr_dbg_ack", dbg_ack, 1);
    check("wr_cpu_ack", cpu_ack, 0);
    dbg_req = 0; dbg_we = 0;
    tick();
    check("wr_ack_pulse", dbg_ack, 0);
    cpu_req = 1; cpu_addr = 16'h4000;
    tick(3);
    check("rb_ack", cpu_ack, 1);
    check("rb_data", cpu_rdata, 16'hBEEF);
    cpu_req = 0;
    tick();

    // MEM_LAT=4 read of 0x0005
    c4_req = 1; c4_addr = 16'h0005;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check($sformatf("lat4_busy_%0d", i), busy4, 1);
      check($sformatf("lat4_ack_%0d", i), c4_ack, (i == 6) ? 1 : 0);
      if (i == 6) begin
        check("lat4_data", c4_rdata, 16'hA5C3);
        c4_req = 0;
      end
    end
    tick();
    check("lat4_idle", busy4, 0);

    // reset asserted during WAIT
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h3000;
    tick(2);
    check("rw_in_wait", busy, 1);
    rst = 1'b0;
    #1;
    check("rw_busy", busy, 0);
    check("rw_mem_en", mem_en, 0);
    check("rw_acks", {cpu_ack, dbg_ack}, 0);
    check("rw_mem_addr", mem_addr, 0);
    cpu_req = 0;
    tick(2);
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen = seen | cpu_ack | dbg_ack | busy;
    end
    check("rw_no_ack_after", seen, 0);

    // both requesting continuously from reset: DBG, CPU, DBG, CPU
    for (int i = 0; i < 4; i++) seq[i] = 2'b00;
    n = 0; prev_c = 0; prev_d = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h3000;
    dbg_req = 1; dbg_we = 0; dbg_addr = 16'h4000;
    for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
      tick();
      if (cpu_ack || dbg_ack) begin
        check("rr_one_ack", {cpu_ack, dbg_ack} == 2'b11, 0);
        check("rr_pulse", (cpu_ack && prev_c) || (dbg_ack && prev_d), 0);
        check("rr_data", cpu_rdata, dbg_ack ? 16'hBEEF : 16'h1234);
        seq[n] = {cpu_ack, dbg_ack};
        n++;
      end
      prev_c = cpu_ack;
      prev_d = dbg_ack;
    end
    cpu_req = 0; dbg_req = 0;
    check("rr_count", n, 4);
    check("rr_g0_dbg", seq[0], 2'b01);
    check("rr_g1_cpu", seq[1], 2'b10);
    check("rr_g2_dbg", seq[2], 2'b01);
    check("rr_g3_cpu", seq[3], 2'b10);
    tick();
    check("rr_last_pulse", {cpu_ack, dbg_ack}, 0);
    tick();

    // halt raised mid CPU read: transaction completes, then CPU is blocked
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h3000;
    tick();
    dbg_halt = 1;
    tick();
    check("h_wait_halted", cpu_halted, 0);
    tick();
    check("h_ack_completes", cpu_ack, 1);
    check("h_done_halted", cpu_halted, 0);
    tick();
    check("h_halted_after", cpu_halted, 1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      seen = seen | cpu_ack | busy;
    end
    check("h_no_grant", seen, 0);
    check("h_halted_hold", cpu_halted, 1);
    dbg_halt = 0;
    tick();
    check("h_release_en", mem_en, 1);
    check("h_release_addr", mem_addr, 16'h3000);
    check("h_release_halted", cpu_halted, 0);
    tick(2);
    check("h_release_ack", cpu_ack, 1);
    cpu_req = 0;
    tick(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
